mem_port_arbiter: RTL and testbench

- Shares the single-port unified word memory between the core's instruction-fetch port and its load/store port.
- Arbitrates one access per cycle, with data priority bounded by a starvation guard on fetch.
- Converts byte addresses to word indices and registers responses.
- Implements byte-enable stores as read-modify-write, because the memory has only whole-word writes.

---
 rtl/mem_port_arbiter_pkg.sv | 30 +++
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types, constants and byte-merge helper for mem_port_arbiter
//
// Purpose : FSM state encoding, byte-enable constants and the read-modify-write
//           merge function used by the memory port arbiter.
// Ports   : none (package).
package mem_port_arbiter_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_t;

   localparam logic [3:0] BE_FULL = 4'hF;
   localparam logic [3:0] BE_NONE = 4'h0;

   // Replace only the byte lanes selected by be; other lanes keep the old word.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port word memory shared by fetch and load/store ports
//
// Purpose : arbitrates one access per cycle between instruction fetch and
//           data ports, data first unless fetch has been starved for
//           STARVE_LIMIT cycles; registers responses; performs partial
//           stores as a two-cycle read-modify-write.
// Ports   : clk, rst (sync, active-low)
//           if_req_*  / if_rsp_*  fetch request/response
//           d_req_*   / d_rsp_*   load/store request/response
//           mem_addr, mem_wr_en, mem_wr_data, mem_rd_data  memory side
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [31:0] if_req_addr,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   output logic        if_rsp_err,
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic [31:0] d_req_addr,
   input  logic        d_req_we,
   input  logic [3:0]  d_req_be,
   input  logic [31:0] d_req_wdata,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_data,
   output logic        d_rsp_err,
   output logic [31:0] mem_addr,
   output logic        mem_wr_en,
   output logic [31:0] mem_wr_data,
   input  logic [31:0] mem_rd_data
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;

   logic               if_rsp_valid_q, if_rsp_valid_d;
   logic [31:0]        if_rsp_data_q, if_rsp_data_d;
   logic               if_rsp_err_q, if_rsp_err_d;
   logic               d_rsp_valid_q, d_rsp_valid_d;
   logic [31:0]        d_rsp_data_q, d_rsp_data_d;
   logic               d_rsp_err_q, d_rsp_err_d;

   // Partial-store context captured in the read cycle, consumed in RMW_WR.
   logic [ADDR_W-1:0]  rmw_idx_q, rmw_idx_d;
   logic [3:0]         rmw_be_q, rmw_be_d;
   logic [31:0]        rmw_wdata_q, rmw_wdata_d;
   logic [31:0]        rmw_old_q, rmw_old_d;

   logic               if_gnt, d_gnt;
   logic               if_mis, d_mis;
   logic [ADDR_W-1:0]  if_idx, d_idx;
   logic [ADDR_W-1:0]  mem_idx;

   // Upper address bits are deliberately ignored so addresses wrap.
   logic               unused_addr_bits;
   assign unused_addr_bits = ^{if_req_addr[31:ADDR_W+2], d_req_addr[31:ADDR_W+2]};

   assign if_mis = (if_req_addr[1:0] != 2'b00);
   assign d_mis  = (d_req_addr[1:0] != 2'b00);
   assign if_idx = if_req_addr[ADDR_W+1:2];
   assign d_idx  = d_req_addr[ADDR_W+1:2];

   // Grant: data wins by default; fetch wins when data is idle or starved out.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (rst && (state_q == IDLE)) begin
         if (if_req_valid && (!d_req_valid || (starve_cnt_q == CNT_MAX))) begin
            if_gnt = 1'b1;
         end else if (d_req_valid) begin
            d_gnt = 1'b1;
         end
      end
   end

   assign if_req_ready = if_gnt;
   assign d_req_ready  = d_gnt;

   // Starvation counter: counts denied fetch cycles, saturating.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!if_req_valid || if_gnt) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != CNT_MAX) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   // Next state, memory side and response registers.
   always_comb begin
      state_d        = state_q;
      mem_idx        = '0;
      mem_wr_en      = 1'b0;
      mem_wr_data    = 32'h0;
      if_rsp_valid_d = 1'b0;
      if_rsp_data_d  = 32'h0;
      if_rsp_err_d   = 1'b0;
      d_rsp_valid_d  = 1'b0;
      d_rsp_data_d   = 32'h0;
      d_rsp_err_d    = 1'b0;
      rmw_idx_d      = rmw_idx_q;
      rmw_be_d       = rmw_be_q;
      rmw_wdata_d    = rmw_wdata_q;
      rmw_old_d      = rmw_old_q;

      case (state_q)
         IDLE: begin
            if (if_gnt) begin
               if_rsp_valid_d = 1'b1;
               if (if_mis) begin
                  if_rsp_err_d = 1'b1;
               end else begin
                  mem_idx       = if_idx;
                  if_rsp_data_d = mem_rd_data;
               end
            end else if (d_gnt) begin
               if (d_mis) begin
                  d_rsp_valid_d = 1'b1;
                  d_rsp_err_d   = 1'b1;
               end else if (!d_req_we) begin
                  mem_idx       = d_idx;
                  d_rsp_valid_d = 1'b1;
                  d_rsp_data_d  = mem_rd_data;
               end else if (d_req_be == BE_FULL) begin
                  mem_idx       = d_idx;
                  mem_wr_en     = 1'b1;
                  mem_wr_data   = d_req_wdata;
                  d_rsp_valid_d = 1'b1;
               end else if (d_req_be == BE_NONE) begin
                  d_rsp_valid_d = 1'b1;
               end else begin
                  // Partial store: read now, write the merged word next cycle.
                  mem_idx     = d_idx;
                  rmw_idx_d   = d_idx;
                  rmw_be_d    = d_req_be;
                  rmw_wdata_d = d_req_wdata;
                  rmw_old_d   = mem_rd_data;
                  state_d     = RMW_WR;
               end
            end
         end
         RMW_WR: begin
            // Gated by rst so a reset in this cycle drops the write.
            if (rst) begin
               mem_idx       = rmw_idx_q;
               mem_wr_en     = 1'b1;
               mem_wr_data   = byte_merge(rmw_old_q, rmw_wdata_q, rmw_be_q);
               d_rsp_valid_d = 1'b1;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_addr = {{(32-ADDR_W){1'b0}}, mem_idx};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         starve_cnt_q   <= '0;
         if_rsp_valid_q <= 1'b0;
         if_rsp_data_q  <= 32'h0;
         if_rsp_err_q   <= 1'b0;
         d_rsp_valid_q  <= 1'b0;
         d_rsp_data_q   <= 32'h0;
         d_rsp_err_q    <= 1'b0;
         rmw_idx_q      <= '0;
         rmw_be_q       <= 4'h0;
         rmw_wdata_q    <= 32'h0;
         rmw_old_q      <= 32'h0;
      end else begin
         state_q        <= state_d;
         starve_cnt_q   <= starve_cnt_d;
         if_rsp_valid_q <= if_rsp_valid_d;
         if_rsp_data_q  <= if_rsp_data_d;
         if_rsp_err_q   <= if_rsp_err_d;
         d_rsp_valid_q  <= d_rsp_valid_d;
         d_rsp_data_q   <= d_rsp_data_d;
         d_rsp_err_q    <= d_rsp_err_d;
         rmw_idx_q      <= rmw_idx_d;
         rmw_be_q       <= rmw_be_d;
         rmw_wdata_q    <= rmw_wdata_d;
         rmw_old_q      <= rmw_old_d;
      end
   end

   assign if_rsp_valid = if_rsp_valid_q;
   assign if_rsp_data  = if_rsp_data_q;
   assign if_rsp_err   = if_rsp_err_q;
   assign d_rsp_valid  = d_rsp_valid_q;
   assign d_rsp_data   = d_rsp_data_q;
   assign d_rsp_err    = d_rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int LIMIT = 4;
   localparam int WORDS = 1024;

   logic        clk;
   logic        rst;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [31:0] if_req_addr;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        if_rsp_err;
   logic        d_req_valid;
   logic        d_req_ready;
   logic [31:0] d_req_addr;
   logic        d_req_we;
   logic [3:0]  d_req_be;
   logic [31:0] d_req_wdata;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_data;
   logic        d_rsp_err;
   logic [31:0] mem_addr;
   logic        mem_wr_en;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   mem_port_arbiter #(.ADDR_W(10), .STARVE_LIMIT(LIMIT)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_req_addr  (if_req_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rsp_data  (if_rsp_data),
      .if_rsp_err   (if_rsp_err),
      .d_req_valid  (d_req_valid),
      .d_req_ready  (d_req_ready),
      .d_req_addr   (d_req_addr),
      .d_req_we     (d_req_we),
      .d_req_be     (d_req_be),
      .d_req_wdata  (d_req_wdata),
      .d_rsp_valid  (d_rsp_valid),
      .d_rsp_data   (d_rsp_data),
      .d_rsp_err    (d_rsp_err),
      .mem_addr     (mem_addr),
      .mem_wr_en    (mem_wr_en),
      .mem_wr_data  (mem_wr_data),
      .mem_rd_data  (mem_rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory device attached to the DUT, with a bench-side preload path.
   logic [31:0] tb_mem [0:WORDS-1];
   logic        ld_en;
   logic [9:0]  ld_idx;
   logic [31:0] ld_data;

   always @(posedge clk) begin
      if (ld_en) tb_mem[ld_idx] <= ld_data;
      else if (mem_wr_en) tb_mem[mem_addr[9:0]] <= mem_wr_data;
   end
   assign mem_rd_data = tb_mem[mem_addr[9:0]];

   // Reference model state.
   bit [31:0] ref_mem [0:WORDS-1];
   int        denied;
   bit        busy;
   int        busy_idx;
   bit [31:0] busy_word;
   bit        e_if_v, e_if_e, e_d_v, e_d_e, n_d_v;
   bit [31:0] e_if_d, e_d_d;
   bit        acc_if, acc_d;

   // Samples taken at the last negedge, for directed constant checks.
   logic        s_if_rdy, s_d_rdy, s_mem_we, s_if_v, s_if_e, s_d_v, s_d_e;
   logic [31:0] s_mem_addr, s_mem_wd, s_if_d, s_d_d;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'((a / 32'd4) % WORDS);
   endfunction

   function automatic bit [31:0] merge(input bit [31:0] old_w, input bit [31:0] new_w,
                                       input bit [3:0] be);
      bit [31:0] mask;
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (be[b]) mask |= (32'hFF << (8 * b));
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   task automatic preload(input int idx, input logic [31:0] data);
      ld_en   = 1'b1;
      ld_idx  = 10'(idx);
      ld_data = data;
      ref_mem[idx] = data;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   // One clock: predict, check at negedge, advance the model after the edge.
   task automatic cycle();
      bit          x_if, x_d, x_we;
      logic [31:0] x_addr, x_wd;
      bit          mis;
      int          idx;
      x_if = 0; x_d = 0; x_we = 0; x_addr = 32'h0; x_wd = 32'h0;
      if (rst && !busy) begin
         if (if_req_valid && (!d_req_valid || denied == LIMIT)) x_if = 1;
         else if (d_req_valid) x_d = 1;
      end
      if (rst && busy) begin
         x_addr = 32'(busy_idx); x_we = 1; x_wd = busy_word;
      end else if (x_if && if_req_addr[1:0] == 2'b00) begin
         x_addr = 32'(widx(if_req_addr));
      end else if (x_d && d_req_addr[1:0] == 2'b00 && !(d_req_we && d_req_be == 4'h0)) begin
         x_addr = 32'(widx(d_req_addr));
         if (d_req_we && d_req_be == 4'hF) begin x_we = 1; x_wd = d_req_wdata; end
      end
      @(negedge clk);
      s_if_rdy = if_req_ready; s_d_rdy = d_req_ready;
      s_mem_addr = mem_addr; s_mem_we = mem_wr_en; s_mem_wd = mem_wr_data;
      s_if_v = if_rsp_valid; s_if_d = if_rsp_data; s_if_e = if_rsp_err;
      s_d_v = d_rsp_valid; s_d_d = d_rsp_data; s_d_e = d_rsp_err;
      chk("if_req_ready", if_req_ready, x_if);
      chk("d_req_ready", d_req_ready, x_d);
      chk("mem_addr", mem_addr, x_addr);
      chk("mem_wr_en", mem_wr_en, x_we);
      chk("mem_wr_data", mem_wr_data, x_wd);
      chk("if_rsp_valid", if_rsp_valid, e_if_v);
      chk("if_rsp_data", if_rsp_data, e_if_d);
      chk("if_rsp_err", if_rsp_err, e_if_e);
      chk("d_rsp_valid", d_rsp_valid, e_d_v);
      chk("d_rsp_data", d_rsp_data, e_d_d);
      chk("d_rsp_err", d_rsp_err, e_d_e);
      @(posedge clk); #1;
      acc_if = x_if && if_req_valid;
      acc_d  = x_d && d_req_valid;
      e_if_v = 0; e_if_d = 0; e_if_e = 0;
      if (!rst) begin
         e_d_v = 0; e_d_d = 0; e_d_e = 0; n_d_v = 0;
         busy = 0; denied = 0;
      end else begin
         e_d_v = n_d_v; e_d_d = 0; e_d_e = 0; n_d_v = 0;
         if (busy) begin ref_mem[busy_idx] = busy_word; busy = 0; end
         if (acc_if) begin
            mis = (if_req_addr[1:0] != 2'b00);
            e_if_v = 1; e_if_e = mis;
            if (!mis) e_if_d = ref_mem[widx(if_req_addr)];
         end
         if (acc_d) begin
            mis = (d_req_addr[1:0] != 2'b00);
            idx = widx(d_req_addr);
            if (mis) begin
               e_d_v = 1; e_d_e = 1;
            end else if (!d_req_we) begin
               e_d_v = 1; e_d_d = ref_mem[idx];
            end else if (d_req_be == 4'hF) begin
               e_d_v = 1; ref_mem[idx] = d_req_wdata;
            end else if (d_req_be == 4'h0) begin
               e_d_v = 1;
            end else begin
               busy = 1; busy_idx = idx;
               busy_word = merge(ref_mem[idx], d_req_wdata, d_req_be);
               n_d_v = 1;
            end
         end
         if (if_req_valid && !acc_if) denied = (denied < LIMIT) ? denied + 1 : LIMIT;
         else denied = 0;
      end
   endtask

   task automatic idle();
      if_req_valid = 1'b0;
      d_req_valid  = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      return a;
   endfunction

   initial begin
      rst = 1'b0; ld_en = 1'b0; ld_idx = 10'h0; ld_data = 32'h0;
      if_req_valid = 1'b0; if_req_addr = 32'h0;
      d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_we = 1'b0;
      d_req_be = 4'h0; d_req_wdata = 32'h0;
      denied = 0; busy = 0; busy_idx = 0; busy_word = 0;
      e_if_v = 0; e_if_d = 0; e_if_e = 0; e_d_v = 0; e_d_d = 0; e_d_e = 0; n_d_v = 0;
      acc_if = 0; acc_d = 0;

      for (int i = 0; i < 16; i++) begin
         if (i == 4) preload(i, 32'hDEAD_BEEF);
         else preload(i, $urandom);
      end

      // Reset state: requests present but readies and memory strobes held low.
      if_req_valid = 1'b1; if_req_addr = 32'h10;
      d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_we = 1'b1; d_req_be = 4'hF;
      cycle();
      chk("rst_if_ready", s_if_rdy, 1'b0);
      chk("rst_mem_wr_en", s_mem_we, 1'b0);
      chk("rst_d_rsp_valid", s_d_v, 1'b0);
      idle(); d_req_we = 1'b0;
      rst = 1'b1;
      cycle();

      // Fetch of 0x10 reads word 4.
      if_req_valid = 1'b1; if_req_addr = 32'h10;
      cycle();
      chk("fetch_mem_addr", s_mem_addr, 32'd4);
      idle();
      cycle();
      chk("fetch_rsp_valid", s_if_v, 1'b1);
      chk("fetch_rsp_data", s_if_d, 32'hDEAD_BEEF);
      chk("fetch_rsp_err", s_if_e, 1'b0);

      // Both ports valid continuously: four data grants then one fetch grant.
      if_req_valid = 1'b1; if_req_addr = 32'h0;
      d_req_valid = 1'b1; d_req_addr = 32'h4; d_req_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("starve_fetch_grant", s_if_rdy, (i % 5) == 4);
      end
      idle();
      cycle();

      // Full-word store to 0x20, then load it back.
      d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_we = 1'b1;
      d_req_be = 4'hF; d_req_wdata = 32'h1234_5678;
      cycle();
      chk("st_full_wr_en", s_mem_we, 1'b1);
      chk("st_full_addr", s_mem_addr, 32'd8);
      idle();
      cycle();
      chk("st_full_rsp", s_d_v, 1'b1);
      d_req_valid = 1'b1; d_req_we = 1'b0;
      cycle();
      idle();
      cycle();
      chk("ld_after_st", s_d_d, 32'h1234_5678);

      // Partial store byte 1, with a competing fetch.
      d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_we = 1'b1;
      d_req_be = 4'h2; d_req_wdata = 32'h0000_AB00;
      if_req_valid = 1'b1; if_req_addr = 32'h10;
      cycle();
      chk("rmw_rd_we", s_mem_we, 1'b0);
      chk("rmw_rd_addr", s_mem_addr, 32'd8);
      d_req_valid = 1'b0;
      cycle();
      chk("rmw_wr_we", s_mem_we, 1'b1);
      chk("rmw_wr_data", s_mem_wd, 32'h1234_AB78);
      chk("rmw_fetch_blocked", s_if_rdy, 1'b0);
      cycle();
      chk("rmw_rsp", s_d_v, 1'b1);
      idle();
      cycle();

      // Misaligned load and fetch.
      d_req_valid = 1'b1; d_req_addr = 32'h22; d_req_we = 1'b0;
      cycle();
      chk("mis_ld_no_access", s_mem_addr, 32'd0);
      idle();
      if_req_valid = 1'b1; if_req_addr = 32'h03;
      cycle();
      chk("mis_ld_err", s_d_e, 1'b1);
      idle();
      cycle();
      chk("mis_fetch_err", s_if_e, 1'b1);

      // Upper address bits wrap onto word 4.
      d_req_valid = 1'b1; d_req_addr = 32'h0000_1010; d_req_we = 1'b0;
      cycle();
      idle();
      cycle();
      chk("wrap_ld_data", s_d_d, 32'hDEAD_BEEF);

      // Reset landing on the write cycle of a partial store.
      d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_we = 1'b1;
      d_req_be = 4'h1; d_req_wdata = 32'h0000_00FF;
      cycle();
      idle();
      rst = 1'b0;
      cycle();
      chk("rst_rmw_wr_en", s_mem_we, 1'b0);
      rst = 1'b1;
      cycle();
      chk("rst_rmw_no_rsp", s_d_v, 1'b0);
      d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_we = 1'b0;
      cycle();
      idle();
      cycle();
      chk("rst_rmw_word_kept", s_d_d, 32'h1234_AB78);
      if_req_valid = 1'b1; if_req_addr = 32'h10;
      cycle();
      idle();
      cycle();
      chk("post_rst_fetch", s_if_d, 32'hDEAD_BEEF);

      // Randomised traffic; requesters hold their request until accepted.
      for (int k = 0; k < 400; k++) begin
         if (!(if_req_valid && !acc_if)) begin
            if_req_valid = ($urandom_range(0, 3) != 0);
            if_req_addr  = rand_addr();
         end
         if (!(d_req_valid && !acc_d)) begin
            d_req_valid = ($urandom_range(0, 2) != 0);
            d_req_addr  = rand_addr();
            d_req_we    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
               0:       d_req_be = 4'hF;
               1:       d_req_be = 4'h0;
               default: d_req_be = 4'($urandom_range(1, 14));
            endcase
            d_req_wdata = $urandom;
         end
         cycle();
      end
      idle();
      cycle();
      cycle();

      for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
